// File: rtl/ps2_scan_receiver.sv
// PS/2 keyboard scan-code receiver.
// Synchronises the raw PS/2 clock/data lines, deframes 11-bit frames
// (start, 8 data LSB-first, odd parity, stop), resolves the E0/F0 prefixes
// and emits one strobe per completed key event.
module ps2_scan_receiver #(
  parameter int TIMEOUT_CYCLES = 5000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic       clock,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] code,
  output logic       is_break,
  output logic       is_ext,
  output logic       code_valid,
  output logic       frame_err
);

  localparam int TCW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TCW-1:0] TIMEOUT_LAST = TCW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_t;

  // Synchroniser chains; both reset to 1 so the bus looks idle.
  logic [SYNC_STAGES-1:0] clk_sync;
  logic [SYNC_STAGES-1:0] data_sync;
  logic                   clk_prev;
  logic                   clk_s;
  logic                   data_s;
  logic                   fall;

  state_t         state_q, state_d;
  logic [2:0]     bit_cnt_q;
  logic [7:0]     shift_q;
  logic           parity_err_q;
  logic [TCW-1:0] tcnt_q;
  logic           ext_q;
  logic           brk_q;

  // Control decoded from the current state and the sampled bus.
  logic timeout;
  logic shift_en;
  logic parity_load;
  logic err_evt;
  logic emit_evt;
  logic set_ext;
  logic set_brk;
  logic clr_flags;

  assign clk_s  = clk_sync[SYNC_STAGES-1];
  assign data_s = data_sync[SYNC_STAGES-1];
  assign fall   = clk_prev & ~clk_s;

  // Input synchronisers plus the delayed clock copy used for edge detection.
  // NOTE: sequential state always uses non-blocking assignments so every
  // flop samples the pre-edge values of the others, regardless of order.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync  <= '1;
      data_sync <= '1;
      clk_prev  <= 1'b1;
    end else begin
      clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
      data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data};
      clk_prev  <= clk_s;
    end
  end

  // FSM state register.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state and control decode; timeout has priority over a falling edge.
  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    timeout     = 1'b0;
    shift_en    = 1'b0;
    parity_load = 1'b0;
    err_evt     = 1'b0;
    emit_evt    = 1'b0;
    set_ext     = 1'b0;
    set_brk     = 1'b0;
    clr_flags   = 1'b0;

    if (state_q != IDLE && tcnt_q == TIMEOUT_LAST) begin
      timeout   = 1'b1;
      state_d   = IDLE;
      err_evt   = 1'b1;
      clr_flags = 1'b1;
    end else if (fall) begin
      unique case (state_q)
        IDLE: begin
          if (!data_s) state_d = DATA;
        end
        DATA: begin
          shift_en = 1'b1;
          if (bit_cnt_q == 3'd7) state_d = PARITY;
        end
        PARITY: begin
          parity_load = 1'b1;
          state_d     = STOP;
        end
        STOP: begin
          state_d = IDLE;
          if (parity_err_q || !data_s) begin
            err_evt   = 1'b1;
            clr_flags = 1'b1;
          end else if (shift_q == 8'hE0) begin
            set_ext = 1'b1;
          end else if (shift_q == 8'hF0) begin
            set_brk = 1'b1;
          end else begin
            emit_evt  = 1'b1;
            clr_flags = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Frame datapath: bit counter, shift register and parity check.
  // NOTE: the shift register is a plain register, not a memory, so it is
  // reset along with the rest of the frame state.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt_q    <= 3'd0;
      shift_q      <= 8'h00;
      parity_err_q <= 1'b0;
    end else begin
      if (state_q == IDLE)  bit_cnt_q <= 3'd0;
      else if (shift_en)    bit_cnt_q <= bit_cnt_q + 3'd1;
      if (shift_en)         shift_q   <= {data_s, shift_q[7:1]};
      // Odd parity: data bits XOR parity bit must be 1.
      if (parity_load)      parity_err_q <= ~(^shift_q ^ data_s);
    end
  end

  // Timeout counter: held at 0 in IDLE, restarted by every falling edge.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n)                              tcnt_q <= '0;
    else if (state_q == IDLE || fall || timeout) tcnt_q <= '0;
    else                                     tcnt_q <= tcnt_q + 1'b1;
  end

  // Prefix flags accumulate across prefix frames until an event or error.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      ext_q <= 1'b0;
      brk_q <= 1'b0;
    end else if (clr_flags) begin
      ext_q <= 1'b0;
      brk_q <= 1'b0;
    end else begin
      if (set_ext) ext_q <= 1'b1;
      if (set_brk) brk_q <= 1'b1;
    end
  end

  // Registered outputs: strobes one cycle after the stop-bit edge.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      code       <= 8'h00;
      is_break   <= 1'b0;
      is_ext     <= 1'b0;
      code_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      code_valid <= emit_evt;
      frame_err  <= err_evt;
      if (emit_evt) begin
        code     <= shift_q;
        is_break <= brk_q;
        is_ext   <= ext_q;
      end
    end
  end

endmodule

// File: tb/tb_ps2_scan_receiver.sv
// Directed bench for ps2_scan_receiver: sends PS/2 frames bit by bit and
// checks the decoded events against hand-computed values.
module tb_ps2_scan_receiver;

  localparam int TIMEOUT_CYCLES = 5000;

  logic       clk;
  logic       rst_n;
  logic       ps2_clk;
  logic       ps2_data;
  logic [7:0] code;
  logic       is_break;
  logic       is_ext;
  logic       code_valid;
  logic       frame_err;

  int checks   = 0;
  int failures = 0;

  // Event monitor state.
  int         valid_cnt = 0;
  int         err_cnt   = 0;
  int         both_cnt  = 0;
  logic [7:0] last_code = 8'h00;
  logic       last_brk  = 1'b0;
  logic       last_ext  = 1'b0;

  ps2_scan_receiver #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .SYNC_STAGES   (2)
  ) dut (
    .clock     (clk),
    .rst_n     (rst_n),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .code      (code),
    .is_break  (is_break),
    .is_ext    (is_ext),
    .code_valid(code_valid),
    .frame_err (frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record strobes on the falling system-clock edge, away from updates.
  always @(negedge clk) begin
    if (code_valid) begin
      valid_cnt = valid_cnt + 1;
      last_code = code;
      last_brk  = is_break;
      last_ext  = is_ext;
    end
    if (frame_err) err_cnt = err_cnt + 1;
    if (code_valid && frame_err) both_cnt = both_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    checks = checks + 1;
    assert (observed === expected) else begin
      failures = failures + 1;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
  endtask

  // Send the first nbits of a frame; par_flip inverts the parity bit.
  task automatic send_bits(input logic [7:0] b, input logic par_flip,
                           input logic stop_bit, input int nbits);
    logic [10:0] fr;
    fr[0]   = 1'b0;
    fr[8:1] = b;
    fr[9]   = (~^b) ^ par_flip;
    fr[10]  = stop_bit;
    for (int i = 0; i < nbits; i++) begin
      ps2_data = fr[i];
      wait_clks(4);
      ps2_clk = 1'b0;
      wait_clks(8);
      ps2_clk = 1'b1;
      wait_clks(4);
    end
    ps2_data = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b);
    send_bits(b, 1'b0, 1'b1, 11);
    wait_clks(10);
  endtask

  initial begin
    int v0;
    int e0;
    rst_n    = 1'b0;
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    wait_clks(5);
    @(negedge clk);
    check("rst_code",  code,       8'h00);
    check("rst_brk",   is_break,   1'b0);
    check("rst_ext",   is_ext,     1'b0);
    check("rst_valid", code_valid, 1'b0);
    check("rst_err",   frame_err,  1'b0);
    rst_n = 1'b1;
    wait_clks(5);

    // Plain make code 1C.
    send_frame(8'h1C);
    check("1c_cnt",  valid_cnt, 1);
    check("1c_code", last_code, 8'h1C);
    check("1c_brk",  last_brk,  1'b0);
    check("1c_ext",  last_ext,  1'b0);
    check("1c_hold", code,      8'h1C);

    // Break: F0 1C, then plain 1C clears the break flag.
    send_frame(8'hF0);
    check("f0_nostrobe", valid_cnt, 1);
    send_frame(8'h1C);
    check("brk_cnt",  valid_cnt, 2);
    check("brk_code", last_code, 8'h1C);
    check("brk_brk",  last_brk,  1'b1);
    check("brk_ext",  last_ext,  1'b0);
    send_frame(8'h1C);
    check("after_brk_cnt", valid_cnt, 3);
    check("after_brk_brk", last_brk,  1'b0);

    // Extended break: E0 F0 75.
    send_frame(8'hE0);
    send_frame(8'hF0);
    check("pfx_nostrobe", valid_cnt, 3);
    send_frame(8'h75);
    check("ext_cnt",  valid_cnt, 4);
    check("ext_code", last_code, 8'h75);
    check("ext_brk",  last_brk,  1'b1);
    check("ext_ext",  last_ext,  1'b1);

    // Parity error, then F0 with a bad stop bit clears the prefix.
    v0 = valid_cnt;
    e0 = err_cnt;
    send_bits(8'h1C, 1'b1, 1'b1, 11);
    wait_clks(10);
    check("par_err", err_cnt,   e0 + 1);
    check("par_nov", valid_cnt, v0);
    check("par_code_hold", code, 8'h75);
    send_bits(8'hF0, 1'b0, 1'b0, 11);
    wait_clks(10);
    check("stop_err", err_cnt, e0 + 2);
    send_frame(8'h1C);
    check("stop_cnt",  valid_cnt, v0 + 1);
    check("stop_code", last_code, 8'h1C);
    check("stop_brk",  last_brk,  1'b0);

    // Timeout after start plus 4 data bits.
    v0 = valid_cnt;
    e0 = err_cnt;
    send_bits(8'h29, 1'b0, 1'b1, 5);
    wait_clks(TIMEOUT_CYCLES - 200);
    check("to_early", err_cnt, e0);
    wait_clks(300);
    check("to_err",  err_cnt,   e0 + 1);
    check("to_nov",  valid_cnt, v0);
    send_frame(8'h29);
    check("to_next_cnt",  valid_cnt, v0 + 1);
    check("to_next_code", last_code, 8'h29);
    check("to_next_err",  err_cnt,   e0 + 1);

    // Reset mid-frame after 6 bits of 5A.
    v0 = valid_cnt;
    e0 = err_cnt;
    send_bits(8'h5A, 1'b0, 1'b1, 6);
    rst_n = 1'b0;
    wait_clks(3);
    @(negedge clk);
    check("mr_code",  code,       8'h00);
    check("mr_brk",   is_break,   1'b0);
    check("mr_ext",   is_ext,     1'b0);
    check("mr_valid", code_valid, 1'b0);
    check("mr_err",   frame_err,  1'b0);
    rst_n = 1'b1;
    wait_clks(20);
    check("mr_nostrobe", valid_cnt, v0);
    send_frame(8'h5A);
    check("mr_cnt",  valid_cnt, v0 + 1);
    check("mr_code5a", last_code, 8'h5A);
    check("mr_flags", {last_brk, last_ext}, 2'b00);
    check("mr_noerr", err_cnt, e0);

    check("never_both", both_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time bound so the run always ends.
  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/ps2_scan_receiver.md
Name: ps2_scan_receiver

Overview:
- Front-end stage that feeds the keyboard key-capture path.
- Samples the raw PS/2 clock and data lines in the system clock domain and deframes 11-bit PS/2 frames.
- Resolves the E0 (extended) and F0 (break) prefixes.
- Emits one single-cycle strobe per completed key event, carrying the scan code and its flags, to the key-register/decoder logic downstream.

Parameters:
- TIMEOUT_CYCLES, 5000, system-clock cycles with no PS/2 falling edge mid-frame before the partial frame is discarded (100 us at 50 MHz).
- SYNC_STAGES, 2, flip-flop depth of the input synchronisers for ps2_clk and ps2_data (legal values 2..3).

Ports:
- clock  input  1  system clock; all logic is on the rising edge.
- rst_n  input  1  reset, asynchronous and active-low.
- ps2_clk  input  1  raw PS/2 clock from the keyboard, asynchronous.
- ps2_data  input  1  raw PS/2 data from the keyboard, asynchronous.
- code  output  8  scan code of the last completed event.
- is_break  output  1  last event was preceded by F0 (key release).
- is_ext  output  1  last event was preceded by E0.
- code_valid  output  1  one-cycle strobe; code, is_break and is_ext are valid in this cycle.
- frame_err  output  1  one-cycle strobe on a parity error, stop-bit error or timeout.

Behaviour:
- Reset (async assert, synchronous release): code=8'h00, is_break=0, is_ext=0, code_valid=0, frame_err=0. FSM goes to IDLE; bit counter, timeout counter, prefix flags and synchronisers clear. Synchroniser reset value is 1 (idle bus).
- Synchronisers: ps2_clk and ps2_data each pass through SYNC_STAGES flops. A falling edge is synced ps2_clk going 1->0 between consecutive cycles; ps2_data is sampled from its synced copy in that same cycle.
- FSM states: IDLE, DATA, PARITY, STOP. All transitions occur only on a falling edge, except timeout.
- IDLE: sampled bit 0 -> DATA, bit count=0. Sampled bit 1 (bad start) -> stay IDLE, no strobe.
- DATA: shift the bit into the shift register LSB-first. After the 8th bit -> PARITY.
- PARITY: error flag set if (XOR of 8 data bits) XOR (parity bit) != 1, i.e. odd parity required. -> STOP.
- STOP: sampled bit must be 1. Result is evaluated in this cycle and the FSM returns to IDLE.
  - Parity error or stop bit 0: pulse frame_err the next cycle; clear both prefix flags; do not update outputs.
  - Byte E0: set the ext prefix flag; no strobe.
  - Byte F0: set the break prefix flag; no strobe.
  - Any other byte: next cycle load code=byte, is_break=break prefix flag, is_ext=ext prefix flag, and pulse code_valid for exactly 1 cycle; then clear both prefix flags.
- Latency: code_valid asserts exactly 1 clock after the cycle in which the stop-bit falling edge is detected.
- code, is_break and is_ext hold their values until the next valid event.
- Timeout:
  - The counter runs while the state is not IDLE and resets on every falling edge.
  - On reaching TIMEOUT_CYCLES-1: FSM -> IDLE, frame_err pulses 1 cycle, prefix flags clear.
  - In IDLE the counter is held at 0.
- A falling edge and a timeout in the same cycle: the timeout wins; the edge is dropped.
- Multiple prefixes accumulate, so E0 F0 xx yields is_ext=1, is_break=1. A repeated F0 has no additional effect.
- Reset asserted mid-frame: the partial frame and prefixes are discarded immediately. No strobe fires on release.
- frame_err and code_valid are never high in the same cycle.

Test Plan:
- Frame 0x1C: start 0, data LSB-first 0,0,1,1,1,0,0,0, parity 0, stop 1 -> code_valid pulses once; code=8'h1C, is_break=0, is_ext=0.
- Frames F0 then 1C -> no strobe after F0; after 1C, code_valid=1 with code=8'h1C and is_break=1. A subsequent plain 1C then gives is_break=0.
- Frames E0, F0, 75 -> a single code_valid with code=8'h75, is_ext=1, is_break=1. No strobe occurs for the prefix frames.
- Frame 0x1C with parity bit 1 -> frame_err pulses 1 cycle and code_valid stays 0. Then send F0 with a bad stop bit followed by 0x1C -> is_break=0 (prefix cleared).
- Timeout: send start plus 4 data bits, then hold ps2_clk high for TIMEOUT_CYCLES -> frame_err pulses once and FSM is in IDLE. A following clean frame 0x29 -> code=8'h29 and code_valid.
- Deassert rst_n after 6 bits of frame 0x5A, release, then send a full frame 0x5A -> exactly one code_valid with code=8'h5A. All outputs read 0 while reset is asserted.
